// File: rtl/bus_master_if.sv
// Single-request bus engine between the control unit and a word memory.
// Runs a req/ready handshake and reports read data, write completion or error.
module bus_master_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              BUS_start_transaction,
  input  logic              BUS_mode,
  input  logic [ADDR_W-1:0] BUS_addr,
  input  logic [DATA_W-1:0] BUS_wdata,
  output logic [DATA_W-1:0] BUS_rdata,
  output logic              BUS_rdata_valid,
  output logic              BUS_write_done,
  output logic              BUS_error,
  output logic              BUS_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  // A zero TIMEOUT still needs a one-bit counter so the logic stays well formed.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic                mem_req_d, mem_we_d;
  logic [ADDR_W-3:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic [DATA_W-1:0]   rdata_d;
  logic                rdata_valid_d, write_done_d, error_d;
  logic                misaligned;
  logic                timeout_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign misaligned  = (BUS_addr[1:0] != 2'b00);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
  assign BUS_busy    = (state != IDLE);

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    mem_req_d     = mem_req;
    mem_we_d      = mem_we;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    rdata_d       = BUS_rdata;
    rdata_valid_d = 1'b0;
    write_done_d  = 1'b0;
    error_d       = 1'b0;

    case (state)
      IDLE: begin
        if (BUS_start_transaction) begin
          if (misaligned) begin
            // Misaligned requests never reach the memory side.
            error_d = 1'b1;
            state_d = RESP;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = BUS_mode;
            mem_addr_d  = BUS_addr[ADDR_W-1:2];
            mem_wdata_d = BUS_wdata;
            cnt_d       = '0;
            state_d     = ACCESS;
          end
        end
      end

      ACCESS: begin
        cnt_d = sat_inc(cnt);
        if (mem_ready) begin
          // Ready takes priority over a timeout landing in the same cycle.
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = RESP;
          if (mem_we) begin
            write_done_d = 1'b1;
          end else begin
            rdata_d       = mem_rdata;
            rdata_valid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          error_d   = 1'b1;
          state_d   = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      BUS_rdata       <= '0;
      BUS_rdata_valid <= 1'b0;
      BUS_write_done  <= 1'b0;
      BUS_error       <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      mem_req         <= mem_req_d;
      mem_we          <= mem_we_d;
      mem_addr        <= mem_addr_d;
      mem_wdata       <= mem_wdata_d;
      BUS_rdata       <= rdata_d;
      BUS_rdata_valid <= rdata_valid_d;
      BUS_write_done  <= write_done_d;
      BUS_error       <= error_d;
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// Bench for bus_master_if: table of transactions against a memory model,
// scoreboard of expected completions, plus reset-mid-access sequence.
module tb_bus_master_if;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              BUS_start_transaction;
  logic              BUS_mode;
  logic [ADDR_W-1:0] BUS_addr;
  logic [DATA_W-1:0] BUS_wdata;
  logic [DATA_W-1:0] BUS_rdata;
  logic              BUS_rdata_valid;
  logic              BUS_write_done;
  logic              BUS_error;
  logic              BUS_busy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .BUS_start_transaction(BUS_start_transaction), .BUS_mode(BUS_mode),
    .BUS_addr(BUS_addr), .BUS_wdata(BUS_wdata), .BUS_rdata(BUS_rdata),
    .BUS_rdata_valid(BUS_rdata_valid), .BUS_write_done(BUS_write_done),
    .BUS_error(BUS_error), .BUS_busy(BUS_busy), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Pulse encoding {rdata_valid, write_done, error}
  localparam logic [2:0] P_RV = 3'b100;
  localparam logic [2:0] P_WD = 3'b010;
  localparam logic [2:0] P_ER = 3'b001;

  typedef struct {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_n;      // wait cycles before ready; -1 = never ready
    logic [31:0] mem_data;
    int          second_cyc;  // cycle to pulse an extra start; -1 = none
    logic        late_ready;  // drive mem_ready during the response cycle
    int          idle_n;
    logic [2:0]  exp_pulse;
    int          exp_lat;
    int          exp_reqs;
    logic [29:0] exp_maddr;
  } vec_t;

  typedef struct {
    logic [2:0]  pulses;
    logic [31:0] rdata;
    int          lat;
  } sb_t;

  sb_t         sb_q[$];
  vec_t        vecs[8];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_rdata = 32'h0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_rdata"}, 64'(BUS_rdata), 64'd0);
    check({tag, "_pulses"}, 64'({BUS_rdata_valid, BUS_write_done, BUS_error}), 64'd0);
    check({tag, "_busy"}, 64'(BUS_busy), 64'd0);
  endtask

  task automatic run_txn(input vec_t v);
    sb_t e;
    sb_t got;
    int  req_cnt;
    int  busy_cnt;
    bit  done;
    e.pulses = v.exp_pulse;
    e.rdata  = (v.exp_pulse == P_RV) ? v.mem_data : model_rdata;
    e.lat    = v.exp_lat;
    sb_q.push_back(e);
    BUS_start_transaction = 1'b1;
    BUS_mode  = v.mode;
    BUS_addr  = v.addr;
    BUS_wdata = v.wdata;
    step();
    BUS_start_transaction = 1'b0;
    req_cnt  = 0;
    busy_cnt = 0;
    done     = 1'b0;
    for (int cyc = 1; cyc <= 64 && !done; cyc++) begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (cyc == v.second_cyc) begin
        BUS_start_transaction = 1'b1;
        BUS_mode = ~v.mode;
        BUS_addr = 32'h80;
      end else begin
        BUS_start_transaction = 1'b0;
      end
      if (BUS_busy) busy_cnt++;
      if (BUS_rdata_valid | BUS_write_done | BUS_error) begin
        done = 1'b1;
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual=%0h required=none",
                   {BUS_rdata_valid, BUS_write_done, BUS_error});
        end else begin
          got = sb_q.pop_front();
          check("pulse_kind", 64'({BUS_rdata_valid, BUS_write_done, BUS_error}), 64'(got.pulses));
          check("rdata", 64'(BUS_rdata), 64'(got.rdata));
          check("latency", 64'(cyc), 64'(got.lat));
          model_rdata = got.rdata;
        end
        check("busy_cycles", 64'(busy_cnt), 64'(v.exp_lat));
        check("req_cycles", 64'(req_cnt), 64'(v.exp_reqs));
        check("req_dropped", 64'(mem_req), 64'd0);
      end else begin
        if (mem_req) begin
          req_cnt++;
          check("mem_addr", 64'(mem_addr), 64'(v.exp_maddr));
          check("mem_we", 64'(mem_we), 64'(v.mode));
          check("mem_wdata", 64'(mem_wdata), 64'(v.wdata));
          if (v.wait_n >= 0 && req_cnt == v.wait_n + 1) begin
            mem_ready = 1'b1;
            mem_rdata = v.mem_data;
          end
        end
        step();
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL completion_wait actual=none required=pulse");
    end
    BUS_start_transaction = 1'b0;
    mem_ready = v.late_ready;
    mem_rdata = 32'h5A5A_A5A5;
    for (int i = 0; i < v.idle_n; i++) begin
      step();
      mem_ready = 1'b0;
      check("idle_busy", 64'(BUS_busy), 64'd0);
      check("idle_req", 64'(mem_req), 64'd0);
      check("idle_pulses", 64'({BUS_rdata_valid, BUS_write_done, BUS_error}), 64'd0);
      check("idle_rdata", 64'(BUS_rdata), 64'(model_rdata));
    end
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    BUS_start_transaction = 1'b0;
    BUS_mode  = 1'b0;
    BUS_addr  = '0;
    BUS_wdata = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;

    //         mode  addr        wdata         wait data          2nd late idle pulse lat reqs maddr
    vecs[0] = '{1'b0, 32'h100, 32'h0,        0,  32'hDEADBEEF, -1, 1'b0, 1, P_RV, 2,  1,  30'h40};
    vecs[1] = '{1'b1, 32'h8,   32'h12345678, 3,  32'h0BADF00D, -1, 1'b0, 1, P_WD, 5,  4,  30'h2};
    vecs[2] = '{1'b0, 32'h102, 32'h0,        0,  32'h11111111, -1, 1'b0, 1, P_ER, 1,  0,  30'h40};
    vecs[3] = '{1'b0, 32'h20,  32'h0,        -1, 32'h22222222, -1, 1'b1, 2, P_ER, 17, 16, 30'h8};
    vecs[4] = '{1'b0, 32'h44,  32'h77,       15, 32'hA5A50F0F, 3,  1'b0, 3, P_RV, 17, 16, 30'h11};
    vecs[5] = '{1'b1, 32'h7,   32'hFFFFFFFF, 0,  32'h33333333, -1, 1'b0, 1, P_ER, 1,  0,  30'h0};
    vecs[6] = '{1'b1, 32'hFFC, 32'hCAFEBABE, 1,  32'h44444444, -1, 1'b0, 1, P_WD, 3,  2,  30'h3FF};
    vecs[7] = '{1'b0, 32'h0,   32'h0,        2,  32'h00000001, -1, 1'b0, 1, P_RV, 4,  3,  30'h0};

    step();
    step();
    check_reset_vals("reset");
    rst = 1'b0;
    step();

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset during the second ACCESS cycle, then a late ready that must be ignored.
    BUS_start_transaction = 1'b1;
    BUS_mode = 1'b0;
    BUS_addr = 32'h200;
    step();
    BUS_start_transaction = 1'b0;
    check("rst_seq_req1", 64'(mem_req), 64'd1);
    step();
    check("rst_seq_req2", 64'(mem_req), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_vals("mid_reset");
    model_rdata = 32'h0;
    mem_ready = 1'b1;
    mem_rdata = 32'h55555555;
    step();
    mem_ready = 1'b0;
    check_reset_vals("late_ready");

    v = '{1'b0, 32'h300, 32'h0, 1, 32'hCAFEF00D, -1, 1'b0, 1, P_RV, 3, 2, 30'hC0};
    run_txn(v);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
